to_upper_gate: RTL and testbench

Registered ASCII lower-to-upper case converter. Each accepted byte in the range 'a'..'z' (0x61..0x7A) is mapped to 'A'..'Z' (0x41..0x5A). Every other 8-bit value, including control characters, DEL and extended codes 0x80..0xFF, passes through unchanged. The block sits in the character datapath as a single-stage pipeline element. Its conversion core is built from primitive gates (and/or/not/nor/xor instances), not behavioural comparisons.

---
 rtl/to_upper_gate.sv | 86 ++++++++
 tb/tb_to_upper_gate.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/to_upper_gate.sv
// Purpose : registered ASCII lower-to-upper converter; the 'a'..'z' detect is built from gate primitives.
// Latency : 1 cycle from in_valid/ascii_in to out_valid/ascii_out/was_lower.
// Backpres: none; accepts one byte every cycle, back-to-back.
//
// Ports:
//   clk        system clock, rising-edge
//   rst_n      synchronous active-low reset
//   in_valid   ascii_in carries a byte this cycle
//   ascii_in   input character code
//   ascii_out  converted character (registered, holds when no new byte)
//   out_valid  ascii_out was updated on the last edge
//   was_lower  the byte in ascii_out was a lowercase letter and was converted
module to_upper_gate (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [7:0] ascii_in,
    output logic [7:0] ascii_out,
    output logic       out_valid,
    output logic       was_lower
);

    // ------------------------------------------------------------------
    // Lowercase detect: ~b7 & b6 & b5 & (b[4:0] != 0) & (b[4:0] <= 26)
    // ------------------------------------------------------------------
    logic nonzero;      // low five bits not all zero (excludes '`')
    logic b1_and_b0;
    logic low_ge27_sel; // b1&b0 | b2 : picks out 27..31 once b4&b3 is known
    logic gt26;         // low five bits in 27..31 (excludes '{'..DEL)
    logic le26;
    logic b7_n;
    logic is_lower;
    logic is_lower_n;
    logic bit5_next;

    or  u_nz    (nonzero, ascii_in[4], ascii_in[3], ascii_in[2], ascii_in[1], ascii_in[0]);
    and u_b10   (b1_and_b0, ascii_in[1], ascii_in[0]);
    or  u_sel   (low_ge27_sel, b1_and_b0, ascii_in[2]);
    and u_gt26  (gt26, ascii_in[4], ascii_in[3], low_ge27_sel);
    not u_le26  (le26, gt26);
    not u_b7n   (b7_n, ascii_in[7]);
    and u_lower (is_lower, b7_n, ascii_in[6], ascii_in[5], nonzero, le26);

    // Clearing bit 5 is the whole conversion; every other bit passes through.
    not u_lown  (is_lower_n, is_lower);
    and u_b5    (bit5_next, ascii_in[5], is_lower_n);

    logic [7:0] out_next;
    assign out_next = {ascii_in[7:6], bit5_next, ascii_in[4:0]};

    // ------------------------------------------------------------------
    // Output register stage
    // ------------------------------------------------------------------
    logic [7:0] ascii_q,     ascii_d;
    logic       was_lower_q, was_lower_d;
    logic       out_valid_q, out_valid_d;

    // Data and flag hold when no byte arrives; only out_valid drops.
    always_comb begin
        ascii_d     = ascii_q;
        was_lower_d = was_lower_q;
        out_valid_d = 1'b0;
        if (in_valid) begin
            ascii_d     = out_next;
            was_lower_d = is_lower;
            out_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ascii_q     <= 8'h00;
            was_lower_q <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            ascii_q     <= ascii_d;
            was_lower_q <= was_lower_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign ascii_out = ascii_q;
    assign was_lower = was_lower_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_to_upper_gate.sv
module tb_to_upper_gate;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] ascii_in;
    logic [7:0] ascii_out;
    logic       out_valid;
    logic       was_lower;

    to_upper_gate dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .ascii_in  (ascii_in),
        .ascii_out (ascii_out),
        .out_valid (out_valid),
        .was_lower (was_lower)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] out;
        logic       lower;
    } sb_t;

    typedef struct {
        logic [7:0] in;
        logic [7:0] exp;
        logic       lower;
    } vec_t;

    sb_t        sb_q[$];
    int         vectors;
    int         miscompares;
    logic       exp_v;
    logic [7:0] held_out;
    logic       held_lower;

    // Behavioural reference, independent of the gate structure in the DUT.
    function automatic sb_t ref_conv(input logic [7:0] b);
        sb_t r;
        if (b >= 8'h61 && b <= 8'h7A) begin
            r.out   = b - 8'h20;
            r.lower = 1'b1;
        end else begin
            r.out   = b;
            r.lower = 1'b0;
        end
        return r;
    endfunction

    task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    // Drive one cycle of stimulus, then check the registered result #1 after the edge.
    task automatic step(input logic v, input logic [7:0] d);
        sb_t e;
        in_valid = v;
        ascii_in = d;
        exp_v    = v && rst_n;
        if (exp_v) sb_q.push_back(ref_conv(d));
        @(posedge clk);
        #1;
        if (!rst_n) begin
            cmp("rst ascii_out", ascii_out, 8'h00);
            cmp("rst out_valid", {7'd0, out_valid}, 8'h00);
            cmp("rst was_lower", {7'd0, was_lower}, 8'h00);
            held_out   = 8'h00;
            held_lower = 1'b0;
        end else begin
            cmp("out_valid", {7'd0, out_valid}, {7'd0, exp_v});
            if (exp_v) begin
                if (sb_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL scoreboard: got output with empty queue");
                end else begin
                    e = sb_q.pop_front();
                    cmp("ascii_out", ascii_out, e.out);
                    cmp("was_lower", {7'd0, was_lower}, {7'd0, e.lower});
                    held_out   = e.out;
                    held_lower = e.lower;
                end
            end else begin
                cmp("hold ascii_out", ascii_out, held_out);
                cmp("hold was_lower", {7'd0, was_lower}, {7'd0, held_lower});
            end
        end
    endtask

    vec_t tbl[$];

    initial begin
        vectors     = 0;
        miscompares = 0;
        held_out    = 8'h00;
        held_lower  = 1'b0;

        // Directed table: letters, pass-through, range edges, extended codes.
        tbl = '{
            '{8'h61, 8'h41, 1'b1}, '{8'h7A, 8'h5A, 1'b1}, '{8'h6D, 8'h4D, 1'b1},
            '{8'h28, 8'h28, 1'b0}, '{8'h48, 8'h48, 1'b0}, '{8'h41, 8'h41, 1'b0},
            '{8'h47, 8'h47, 1'b0}, '{8'h30, 8'h30, 1'b0}, '{8'h3A, 8'h3A, 1'b0},
            '{8'h7C, 8'h7C, 1'b0}, '{8'h14, 8'h14, 1'b0},
            '{8'h60, 8'h60, 1'b0}, '{8'h7B, 8'h7B, 1'b0}, '{8'h7F, 8'h7F, 1'b0},
            '{8'h61, 8'h41, 1'b1}, '{8'h7A, 8'h5A, 1'b1},
            '{8'hB7, 8'hB7, 1'b0}, '{8'h83, 8'h83, 1'b0}, '{8'hEB, 8'hEB, 1'b0},
            '{8'h92, 8'h92, 1'b0}, '{8'hCF, 8'hCF, 1'b0}, '{8'h94, 8'h94, 1'b0},
            '{8'hE1, 8'hE1, 1'b0}, '{8'hFA, 8'hFA, 1'b0}
        };

        // Reset held two cycles with a valid lowercase byte presented: discarded.
        rst_n = 1'b0;
        step(1'b1, 8'h61);
        step(1'b1, 8'h61);
        rst_n = 1'b1;
        step(1'b1, 8'h61);
        cmp("post-reset first", ascii_out, 8'h41);

        // Directed vectors back-to-back, each checked against its table constant too.
        for (int i = 0; i < tbl.size(); i++) begin
            step(1'b1, tbl[i].in);
            cmp("tbl ascii_out", ascii_out, tbl[i].exp);
            cmp("tbl was_lower", {7'd0, was_lower}, {7'd0, tbl[i].lower});
        end

        // Valid gap: output and flag hold, out_valid pulses once.
        step(1'b1, 8'h62);
        cmp("gap first", ascii_out, 8'h42);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 8'h63);
            cmp("gap hold ascii", ascii_out, 8'h42);
            cmp("gap hold lower", {7'd0, was_lower}, 8'h01);
        end

        // Mid-stream reset overrides a valid input.
        rst_n = 1'b0;
        step(1'b1, 8'h7A);
        rst_n = 1'b1;
        step(1'b0, 8'h00);

        // Exhaustive sweep.
        for (int b = 0; b < 256; b++) step(1'b1, b[7:0]);
        step(1'b0, 8'h00);

        if (sb_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL scoreboard drain: %0d entries left, expected 0", sb_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
